// File: rtl/modexp_arbiter.sv
// Round-robin front end for a single shared modular-exponent datapath.
// One request is accepted at a time. Its operands are latched, the datapath is
// driven with start/done, a watchdog bounds the busy phase, and the tagged
// result is returned on a valid/ready response port.
//
//   state | meaning
//   IDLE  | arbitrating; req_ready asserted for the round-robin winner
//   BUSY  | dp_start high, waiting for a qualified dp_done or the watchdog
//   RESP  | response held on resp_* until resp_ready
module modexp_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ID_W      = 2,
   parameter int WIDTH     = 32,
   parameter int TIMEOUT   = 1023,
   parameter int DONE_MASK = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   input  logic [N_REQ*WIDTH-1:0] req_c,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   resp_valid,
   output logic [ID_W-1:0]        resp_id,
   output logic [WIDTH-1:0]       resp_data,
   output logic                   resp_err,
   input  logic                   resp_ready,
   output logic                   dp_start,
   output logic [WIDTH-1:0]       dp_a,
   output logic [WIDTH-1:0]       dp_b,
   output logic [WIDTH-1:0]       dp_c,
   input  logic                   dp_done,
   input  logic [WIDTH-1:0]       dp_out,
   output logic                   busy
);

   // Counter only ever reaches TIMEOUT-1 before leaving BUSY.
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MASK = CNT_W'(DONE_MASK);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  grant_id;
   logic [ID_W-1:0]  cand;
   logic             grant_found;
   logic [ID_W-1:0]  lat_id;
   logic [CNT_W-1:0] counter;
   logic [WIDTH-1:0] lat_a;
   logic [WIDTH-1:0] lat_b;
   logic [WIDTH-1:0] lat_c;
   logic [WIDTH-1:0] res_data;
   logic             res_err;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [WIDTH-1:0] sel_c;
   logic             accept;
   logic             done_q;
   logic             timeout_hit;

   // Round-robin scan starting at rr_ptr; index arithmetic wraps in ID_W bits.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      cand        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = rr_ptr + ID_W'(k);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
      end
   end

   assign sel_a = req_a[grant_id*WIDTH +: WIDTH];
   assign sel_b = req_b[grant_id*WIDTH +: WIDTH];
   assign sel_c = req_c[grant_id*WIDTH +: WIDTH];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic, grant and BUSY-exit qualification.
   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      done_q      = 1'b0;
      timeout_hit = 1'b0;
      req_ready   = '0;
      case (state)
         IDLE: begin
            if (grant_found) begin
               accept     = 1'b1;
               req_ready  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
               state_next = (sel_c == '0) ? RESP : BUSY;
            end
         end
         BUSY: begin
            // Early done pulses may be left over from the previous operation.
            done_q      = dp_done && (counter >= CNT_MASK);
            timeout_hit = (counter == CNT_LAST);
            if (done_q || timeout_hit) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand latch, round-robin pointer, watchdog counter and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= '0;
         counter  <= '0;
         lat_id   <= '0;
         lat_a    <= '0;
         lat_b    <= '0;
         lat_c    <= '0;
         res_data <= '0;
         res_err  <= 1'b0;
      end else begin
         if (accept) begin
            lat_a   <= sel_a;
            lat_b   <= sel_b;
            lat_c   <= sel_c;
            lat_id  <= grant_id;
            rr_ptr  <= grant_id + ID_W'(1);
            counter <= '0;
            if (sel_c == '0) begin
               res_data <= '0;
               res_err  <= 1'b1;
            end
         end
         if (state == BUSY) begin
            counter <= counter + CNT_W'(1);
            if (done_q) begin
               res_data <= dp_out;
               res_err  <= 1'b0;
            end else if (timeout_hit) begin
               res_data <= '0;
               res_err  <= 1'b1;
            end
         end
      end
   end

   assign dp_start   = (state == BUSY);
   assign dp_a       = lat_a;
   assign dp_b       = lat_b;
   assign dp_c       = lat_c;
   assign resp_valid = (state == RESP);
   assign resp_id    = lat_id;
   assign resp_data  = res_data;
   assign resp_err   = res_err;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_modexp_arbiter.sv
// Directed bench for modexp_arbiter with a scripted datapath stand-in.
module tb_modexp_arbiter;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;
   localparam int WIDTH = 32;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [N_REQ-1:0]       req_valid = '0;
   logic [N_REQ*WIDTH-1:0] req_a = '0;
   logic [N_REQ*WIDTH-1:0] req_b = '0;
   logic [N_REQ*WIDTH-1:0] req_c = '0;
   logic [N_REQ-1:0]       req_ready;
   logic                   resp_valid;
   logic [ID_W-1:0]        resp_id;
   logic [WIDTH-1:0]       resp_data;
   logic                   resp_err;
   logic                   resp_ready = 1'b0;
   logic                   dp_start;
   logic [WIDTH-1:0]       dp_a, dp_b, dp_c;
   logic                   dp_done = 1'b0;
   logic [WIDTH-1:0]       dp_out = '0;
   logic                   busy;

   modexp_arbiter #(
      .N_REQ(N_REQ), .ID_W(ID_W), .WIDTH(WIDTH), .TIMEOUT(16), .DONE_MASK(2)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_c(req_c),
      .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
      .resp_err(resp_err), .resp_ready(resp_ready),
      .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
      .dp_done(dp_done), .dp_out(dp_out),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Datapath stand-in: counts BUSY cycles and raises dp_done on a scripted one.
   int          done_at  = -1;
   logic [31:0] done_val = '0;
   bit          stale_en = 1'b0;
   int          bcnt     = 0;

   always @(negedge clk) begin
      if (dp_start) begin
         dp_done = 1'b0;
         dp_out  = '0;
         if (stale_en && bcnt == 0) begin
            dp_done = 1'b1;
            dp_out  = 32'd99;
         end
         if (done_at >= 0 && bcnt == done_at) begin
            dp_done = 1'b1;
            dp_out  = done_val;
         end
         bcnt++;
      end else begin
         bcnt    = 0;
         dp_done = 1'b0;
         dp_out  = '0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1, "time limit");
   end

   task automatic set_slot(input int id, input logic [31:0] a, b, c);
      req_a[id*WIDTH +: WIDTH] = a;
      req_b[id*WIDTH +: WIDTH] = b;
      req_c[id*WIDTH +: WIDTH] = c;
   endtask

   task automatic wait_grant(output int g);
      g = -1;
      for (int i = 0; i < 20; i++) begin
         if (req_ready != '0) begin
            for (int k = 0; k < N_REQ; k++) if (req_ready[k]) g = k;
            break;
         end
         @(negedge clk); #1;
      end
   endtask

   // Called at the accept cycle; lat counts cycles until resp_valid is seen.
   task automatic wait_resp(input logic [31:0] ea, eb, ec, input bit scramble,
                            output int first_start, output int start_cnt,
                            output int lat, output int bad);
      first_start = -1;
      start_cnt   = 0;
      lat         = -1;
      bad         = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk); #1;
         if (scramble) begin
            req_a = {$urandom, $urandom, $urandom, $urandom};
            req_b = {$urandom, $urandom, $urandom, $urandom};
         end
         if (busy && req_ready != '0) bad++;
         if (dp_start) begin
            start_cnt++;
            if (first_start < 0) first_start = i;
            if (dp_a !== ea || dp_b !== eb || dp_c !== ec) bad++;
         end
         if (resp_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic handshake(input bit drop);
      resp_ready = 1'b1;
      if (drop) req_valid = '0;
      chk("no_grant_in_hs", 64'(req_ready), 64'd0);
      @(negedge clk); #1;
      resp_ready = 1'b0;
      chk("resp_cleared", 64'(resp_valid), 64'd0);
   endtask

   int g, fs, sc, lat, bad;
   int exp_order [6] = '{0, 2, 0, 2, 3, 0};
   logic [31:0] hold_data;
   logic [1:0]  hold_id;

   initial begin
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b0;
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_dp_start", 64'(dp_start), 64'd0);
      chk("rst_resp_id", 64'(resp_id), 64'd0);
      chk("rst_resp_data", 64'(resp_data), 64'd0);
      chk("rst_resp_err", 64'(resp_err), 64'd0);
      chk("rst_dp_a", 64'(dp_a), 64'd0);

      // Single request: 3^4 mod 20 = 1, done at BUSY cycle 5.
      set_slot(1, 32'd3, 32'd4, 32'd20);
      done_at = 5; done_val = 32'd1;
      req_valid = 4'b0010; #1;
      wait_grant(g);
      chk("single_grant", 64'(g), 64'd1);
      wait_resp(32'd3, 32'd4, 32'd20, 1'b1, fs, sc, lat, bad);
      chk("single_first_start", 64'(fs), 64'd1);
      chk("single_start_cycles", 64'(sc), 64'd6);
      chk("single_resp_lat", 64'(lat), 64'd7);
      chk("single_id", 64'(resp_id), 64'd1);
      chk("single_data", 64'(resp_data), 64'd1);
      chk("single_err", 64'(resp_err), 64'd0);
      chk("single_operands_stable", 64'(bad), 64'd0);
      handshake(1'b1);

      // Fairness from a fresh reset.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1; rst = 1'b0;
      for (int s = 0; s < N_REQ; s++) set_slot(s, 32'(s + 2), 32'd1, 32'd13);
      done_at = 2; done_val = 32'h55;
      req_valid = 4'b0101; #1;
      for (int op = 0; op < 6; op++) begin
         if (op == 3) begin
            req_valid = 4'b1101; #1;
         end
         wait_grant(g);
         chk($sformatf("fair_grant_%0d", op), 64'(g), 64'(exp_order[op]));
         wait_resp(32'(exp_order[op] + 2), 32'd1, 32'd13, 1'b0, fs, sc, lat, bad);
         chk($sformatf("fair_id_%0d", op), 64'(resp_id), 64'(exp_order[op]));
         chk($sformatf("fair_data_%0d", op), 64'(resp_data), 64'h55);
         chk($sformatf("fair_clean_%0d", op), 64'(bad), 64'd0);
         handshake(op == 5);
      end

      // Watchdog: datapath never finishes.
      done_at = -1;
      set_slot(2, 32'd7, 32'd9, 32'd11);
      req_valid = 4'b0100; #1;
      wait_grant(g);
      chk("to_grant", 64'(g), 64'd2);
      wait_resp(32'd7, 32'd9, 32'd11, 1'b0, fs, sc, lat, bad);
      chk("to_start_cycles", 64'(sc), 64'd16);
      chk("to_lat", 64'(lat), 64'd17);
      chk("to_err", 64'(resp_err), 64'd1);
      chk("to_data", 64'(resp_data), 64'd0);
      handshake(1'b1);

      // Stale done in BUSY cycle 0 must be ignored; 19^28 mod 10 = 1.
      stale_en = 1'b1; done_at = 4; done_val = 32'd1;
      set_slot(0, 32'd19, 32'd28, 32'd10);
      req_valid = 4'b0001; #1;
      wait_grant(g);
      chk("stale_grant", 64'(g), 64'd0);
      wait_resp(32'd19, 32'd28, 32'd10, 1'b0, fs, sc, lat, bad);
      chk("stale_start_cycles", 64'(sc), 64'd5);
      chk("stale_data", 64'(resp_data), 64'd1);
      chk("stale_err", 64'(resp_err), 64'd0);
      handshake(1'b1);
      stale_en = 1'b0;

      // Zero modulus, then backpressure with another requester waiting.
      set_slot(1, 32'd5, 32'd3, 32'd0);
      set_slot(3, 32'd5, 32'd3, 32'd7);
      done_at = 2; done_val = 32'd6;
      req_valid = 4'b1010; #1;
      wait_grant(g);
      chk("zero_grant", 64'(g), 64'd1);
      wait_resp(32'd5, 32'd3, 32'd0, 1'b0, fs, sc, lat, bad);
      chk("zero_lat", 64'(lat), 64'd1);
      chk("zero_no_start", 64'(sc), 64'd0);
      chk("zero_err", 64'(resp_err), 64'd1);
      chk("zero_data", 64'(resp_data), 64'd0);
      chk("zero_id", 64'(resp_id), 64'd1);
      hold_data = resp_data; hold_id = resp_id;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         if (!resp_valid || resp_id !== hold_id || resp_data !== hold_data || resp_err !== 1'b1) bad++;
         if (req_ready != '0 || dp_start) bad++;
      end
      chk("bp_stable", 64'(bad), 64'd0);
      handshake(1'b1);

      // Reset during BUSY cycle 3: request is dropped.
      done_at = -1;
      set_slot(3, 32'd2, 32'd2, 32'd9);
      req_valid = 4'b1000; #1;
      wait_grant(g);
      chk("rb_grant", 64'(g), 64'd3);
      repeat (4) @(negedge clk);
      #1;
      chk("rb_busy_before", 64'(dp_start), 64'd1);
      rst = 1'b1; req_valid = '0;
      @(negedge clk); #1;
      rst = 1'b0;
      chk("rb_dp_start", 64'(dp_start), 64'd0);
      chk("rb_busy", 64'(busy), 64'd0);
      chk("rb_resp_valid", 64'(resp_valid), 64'd0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (resp_valid || busy) bad++;
      end
      chk("rb_no_resp", 64'(bad), 64'd0);
      set_slot(3, 32'd24, 32'd1, 32'd25);
      done_at = 3; done_val = 32'd24;
      req_valid = 4'b1000; #1;
      wait_grant(g);
      chk("rb2_grant", 64'(g), 64'd3);
      wait_resp(32'd24, 32'd1, 32'd25, 1'b0, fs, sc, lat, bad);
      chk("rb2_start_cycles", 64'(sc), 64'd4);
      chk("rb2_data", 64'(resp_data), 64'd24);
      chk("rb2_err", 64'(resp_err), 64'd0);
      chk("rb2_id", 64'(resp_id), 64'd3);
      handshake(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
